// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Each grant runs one access and returns a one-cycle Ack; reads also capture RData.
module mem_arbiter #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [1:0]           Req,
  input  logic [1:0]           Wr,
  input  logic [AddrWidth-1:0] Addr0,
  input  logic [AddrWidth-1:0] Addr1,
  input  logic [DataWidth-1:0] WData0,
  input  logic [DataWidth-1:0] WData1,
  output logic [1:0]           Ack,
  output logic [1:0]           Gnt,
  output logic [DataWidth-1:0] RData,
  output logic                 Busy,
  output logic [AddrWidth-1:0] Mem_Address,
  output logic [DataWidth-1:0] Mem_DIn,
  output logic                 Mem_Write_EN,
  input  logic [DataWidth-1:0] Mem_DOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t state;
  logic   ptr;
  logic   gidx;
  logic   is_write;
  logic   pick;

  // A lone requester always wins; on contention the pointer decides.
  assign pick = (Req == 2'b11) ? ptr : Req[1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      gidx         <= 1'b0;
      is_write     <= 1'b0;
      Ack          <= 2'b00;
      Gnt          <= 2'b00;
      Busy         <= 1'b0;
      Mem_Address  <= '0;
      Mem_DIn      <= '0;
      Mem_Write_EN <= 1'b1;
      RData        <= '0;
    end else begin
      case (state)
        IDLE: begin
          Ack          <= 2'b00;
          Gnt          <= 2'b00;
          Mem_Write_EN <= 1'b1;
          Busy         <= 1'b0;
          if (Req != 2'b00) begin
            gidx         <= pick;
            is_write     <= Wr[pick];
            Mem_Address  <= pick ? Addr1 : Addr0;
            Mem_DIn      <= pick ? WData1 : WData0;
            Mem_Write_EN <= ~Wr[pick];
            Gnt          <= pick ? 2'b10 : 2'b01;
            Busy         <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // The memory acts on the edge closing this cycle, so the strobe drops here.
          Mem_Write_EN <= 1'b1;
          if (is_write) begin
            Ack   <= Gnt;
            ptr   <= ~gidx;
            state <= DONE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          RData <= Mem_DOut;
          Ack   <= Gnt;
          ptr   <= ~gidx;
          state <= DONE;
        end
        DONE: begin
          Ack   <= 2'b00;
          Gnt   <= 2'b00;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory, shadow memory for expected
// data, and an Ack scoreboard checked on the falling edge.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [1:0]    Req, Wr;
  logic [AW-1:0] Addr0, Addr1;
  logic [DW-1:0] WData0, WData1;
  logic [1:0]    Ack, Gnt;
  logic [DW-1:0] RData;
  logic          Busy;
  logic [AW-1:0] Mem_Address;
  logic [DW-1:0] Mem_DIn;
  logic          Mem_Write_EN;
  logic [DW-1:0] Mem_DOut;

  mem_arbiter #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack(Ack), .Gnt(Gnt), .RData(RData), .Busy(Busy),
    .Mem_Address(Mem_Address), .Mem_DIn(Mem_DIn),
    .Mem_Write_EN(Mem_Write_EN), .Mem_DOut(Mem_DOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    int            cycle;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] last_rd;
  logic          load_mem;
  logic          prev_we_low = 1'b0;
  int            cyc = 0;
  int            tests_run = 0;
  int            tests_failed = 0;
  int            k;

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 257 + 3);
  endfunction

  // Single-port memory with one-cycle synchronous read.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else begin
      if (!Mem_Write_EN) mem[Mem_Address] <= Mem_DIn;
      Mem_DOut <= mem[Mem_Address];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] wr,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    Req = req; Wr = wr; Addr0 = a0; Addr1 = a1; WData0 = d0; WData1 = d1;
  endtask

  task automatic expectAck(input int who, input bit is_read, input logic [AW-1:0] addr,
                           input int at_cycle);
    exp_t e;
    if (is_read) last_rd = shadow[addr];
    e.ack   = (who == 1) ? 2'b10 : 2'b01;
    e.rdata = last_rd;
    e.cycle = at_cycle;
    sbq.push_back(e);
  endtask

  // Ack monitor: every pulse must match the head of the scoreboard in cycle, owner and data.
  always @(negedge Clk) begin
    exp_t e;
    if (!Mem_Write_EN) checkOutput("we_single_cycle", 32'(prev_we_low), 32'h0);
    prev_we_low <= !Mem_Write_EN;
    if (Ack != 2'b00) begin
      checkOutput("ack_onehot", 32'($countones(Ack)), 32'h1);
      if (sbq.size() == 0) begin
        checkOutput("unexpected_ack", 32'(Ack), 32'h0);
      end else begin
        e = sbq.pop_front();
        checkOutput("ack_owner", 32'(Ack), 32'(e.ack));
        checkOutput("ack_cycle", 32'(cyc), 32'(e.cycle));
        checkOutput("ack_rdata", 32'(RData), 32'(e.rdata));
        checkOutput("ack_busy", 32'(Busy), 32'h1);
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].cycle) begin
      e = sbq.pop_front();
      checkOutput("missing_ack", 32'(Ack), 32'(e.ack));
    end
  end

  initial begin
    Reset = 1'b1;
    load_mem = 1'b1;
    last_rd = '0;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    repeat (3) @(negedge Clk);
    load_mem = 1'b0;
    checkOutput("rst_ack", 32'(Ack), 32'h0);
    checkOutput("rst_gnt", 32'(Gnt), 32'h0);
    checkOutput("rst_busy", 32'(Busy), 32'h0);
    checkOutput("rst_we", 32'(Mem_Write_EN), 32'h1);
    checkOutput("rst_addr", 32'(Mem_Address), 32'h0);
    checkOutput("rst_din", 32'(Mem_DIn), 32'h0);
    checkOutput("rst_rdata", 32'(RData), 32'h0);
    Reset = 1'b0;

    // Simultaneous reads right after reset: requester 0 first, then 1.
    @(negedge Clk); k = cyc;
    applyStimulus(2'b11, 2'b00, 8'h30, 8'h31, '0, '0);
    expectAck(0, 1, 8'h30, k + 3);
    @(negedge Clk);
    checkOutput("sim_gnt_access", 32'(Gnt), 32'h1);
    checkOutput("sim_busy", 32'(Busy), 32'h1);
    repeat (2) @(negedge Clk);
    checkOutput("sim_gnt_done", 32'(Gnt), 32'h1);
    applyStimulus(2'b10, 2'b00, 8'h30, 8'h31, '0, '0);
    expectAck(1, 1, 8'h31, k + 7);
    @(negedge Clk);
    checkOutput("sim_gnt_idle", 32'(Gnt), 32'h0);
    checkOutput("sim_busy_idle", 32'(Busy), 32'h0);
    @(negedge Clk);
    checkOutput("sim_gnt_second", 32'(Gnt), 32'h2);
    repeat (2) @(negedge Clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);

    // Both requesters hold Req through four writes: grants alternate 0,1,0,1.
    @(negedge Clk); k = cyc;
    applyStimulus(2'b11, 2'b11, 8'h40, 8'h41, 16'h1111, 16'h2222);
    shadow[8'h40] = 16'h1111;
    shadow[8'h41] = 16'h2222;
    expectAck(0, 0, 8'h40, k + 2);
    expectAck(1, 0, 8'h41, k + 5);
    expectAck(0, 0, 8'h40, k + 8);
    expectAck(1, 0, 8'h41, k + 11);
    repeat (4) @(negedge Clk);
    checkOutput("fair_gnt_second", 32'(Gnt), 32'h2);
    repeat (7) @(negedge Clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);

    // Single write then read back of the same address.
    @(negedge Clk); k = cyc;
    applyStimulus(2'b01, 2'b01, 8'h05, '0, 16'hBEEF, '0);
    shadow[8'h05] = 16'hBEEF;
    expectAck(0, 0, 8'h05, k + 2);
    @(negedge Clk);
    checkOutput("wr_we_low", 32'(Mem_Write_EN), 32'h0);
    checkOutput("wr_addr", 32'(Mem_Address), 32'h05);
    checkOutput("wr_din", 32'(Mem_DIn), 32'hBEEF);
    @(negedge Clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge Clk); k = cyc;
    applyStimulus(2'b01, 2'b00, 8'h05, '0, '0, '0);
    expectAck(0, 1, 8'h05, k + 3);
    @(negedge Clk);
    checkOutput("rd_we_high", 32'(Mem_Write_EN), 32'h1);
    repeat (2) @(negedge Clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);

    // Requester 1 drops Req and changes data during ACCESS; the captured operands stand.
    @(negedge Clk); k = cyc;
    applyStimulus(2'b10, 2'b10, '0, 8'h10, '0, 16'h1234);
    shadow[8'h10] = 16'h1234;
    expectAck(1, 0, 8'h10, k + 2);
    @(negedge Clk);
    applyStimulus(2'b00, 2'b00, '0, 8'h10, '0, 16'hFFFF);
    checkOutput("drop_din", 32'(Mem_DIn), 32'h1234);
    repeat (2) @(negedge Clk); k = cyc;
    applyStimulus(2'b10, 2'b00, '0, 8'h10, '0, 16'hFFFF);
    expectAck(1, 1, 8'h10, k + 3);
    @(negedge Clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (2) @(negedge Clk);

    // Reset lands on the ACCESS edge of a write: data commits, no Ack.
    @(negedge Clk); k = cyc;
    applyStimulus(2'b01, 2'b01, 8'h20, '0, 16'hAAAA, '0);
    shadow[8'h20] = 16'hAAAA;
    @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge Clk);
    checkOutput("rstw_ack", 32'(Ack), 32'h0);
    checkOutput("rstw_busy", 32'(Busy), 32'h0);
    checkOutput("rstw_gnt", 32'(Gnt), 32'h0);
    checkOutput("rstw_we", 32'(Mem_Write_EN), 32'h1);
    checkOutput("rstw_addr", 32'(Mem_Address), 32'h0);
    checkOutput("rstw_din", 32'(Mem_DIn), 32'h0);
    checkOutput("rstw_rdata", 32'(RData), 32'h0);
    Reset = 1'b0;
    last_rd = '0;
    @(negedge Clk); k = cyc;
    applyStimulus(2'b01, 2'b00, 8'h20, '0, '0, '0);
    expectAck(0, 1, 8'h20, k + 3);
    @(negedge Clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (2) @(negedge Clk);

    // Reset during CAPTURE of a read: no Ack, RData cleared, pointer back to 0.
    @(negedge Clk); k = cyc;
    applyStimulus(2'b01, 2'b00, 8'h30, '0, '0, '0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge Clk);
    checkOutput("rstr_ack", 32'(Ack), 32'h0);
    checkOutput("rstr_rdata", 32'(RData), 32'h0);
    checkOutput("rstr_busy", 32'(Busy), 32'h0);
    Reset = 1'b0;
    last_rd = '0;
    @(negedge Clk); k = cyc;
    applyStimulus(2'b11, 2'b11, 8'h50, 8'h51, 16'h5555, 16'h6666);
    shadow[8'h50] = 16'h5555;
    shadow[8'h51] = 16'h6666;
    expectAck(0, 0, 8'h50, k + 2);
    @(negedge Clk);
    checkOutput("rstr_ptr_gnt", 32'(Gnt), 32'h1);
    @(negedge Clk);
    applyStimulus(2'b10, 2'b10, 8'h50, 8'h51, 16'h5555, 16'h6666);
    expectAck(1, 0, 8'h51, k + 5);
    repeat (3) @(negedge Clk);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);

    // Reset wins over a request sampled on the same edge.
    @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(2'b01, 2'b01, 8'h60, '0, 16'h7777, '0);
    @(negedge Clk);
    checkOutput("rstp_busy", 32'(Busy), 32'h0);
    checkOutput("rstp_gnt", 32'(Gnt), 32'h0);
    checkOutput("rstp_we", 32'(Mem_Write_EN), 32'h1);
    Reset = 1'b0;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);

    repeat (6) @(negedge Clk);
    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
